// File: rtl/clock_manager_if.sv
// rtl/clock_manager_if.sv - lock, divisor and reset/enable bundle for clock_manager.
// Optional CLOCK_MANAGER_LOSS_COUNT_EN adds loss_count.
interface clock_manager_if #(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = 8
);
   logic                    locked;
   logic [NUM_CH*DIV_W-1:0] div_in;
   logic                    clear_lost;
   logic                    sys_reset_n;
   logic [NUM_CH-1:0]       ce;
   logic                    lock_lost;
   logic [1:0]              state;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
   logic [7:0]              loss_count;

   modport master (
      output locked, div_in, clear_lost,
      input  sys_reset_n, ce, lock_lost, state, loss_count
   );
   modport slave (
      input  locked, div_in, clear_lost,
      output sys_reset_n, ce, lock_lost, state, loss_count
   );
`else
   modport master (
      output locked, div_in, clear_lost,
      input  sys_reset_n, ce, lock_lost, state
   );
   modport slave (
      input  locked, div_in, clear_lost,
      output sys_reset_n, ce, lock_lost, state
   );
`endif
endinterface

// File: rtl/clock_manager.sv
// rtl/clock_manager.sv - PLL lock filter, system reset sequencer and clock-enable dividers.
// Optional CLOCK_MANAGER_LOSS_COUNT_EN adds an 8-bit saturating lock-loss counter.
module clock_manager #(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 8,
   parameter int LOCK_FILTER = 1024,
   parameter int RESET_HOLD  = 16
) (
   input logic           clock_in,
   input logic           reset_n,
   clock_manager_if.slave io
);
   localparam int FW = $clog2(LOCK_FILTER) + 1;
   localparam int HW = $clog2(RESET_HOLD) + 1;
   localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER - 1);
   localparam logic [HW-1:0] H_LAST = HW'(RESET_HOLD - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t            st;
   logic              sync1;
   logic              lock_s;
   logic [FW-1:0]     fcnt;
   logic [HW-1:0]     hcnt;
   logic [DIV_W-1:0]  cnt [NUM_CH];
   logic              sys_rst_q;
   logic              lost_q;
   logic [NUM_CH-1:0] ce_q;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
   logic [7:0]        loss_q;
`endif

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= io.locked;
         lock_s <= sync1;
      end
   end

   // Each divider counter doubles as the divisor shadow: it only takes a new
   // div_in value on the cycle its pulse fires, so mid-period edits cannot glitch.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         st        <= WAIT_LOCK;
         fcnt      <= '0;
         hcnt      <= '0;
         sys_rst_q <= 1'b0;
         ce_q      <= '0;
         lost_q    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
         loss_q    <= '0;
`endif
      end else begin
         ce_q   <= '0;
         lost_q <= lost_q & ~io.clear_lost;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= io.div_in[i*DIV_W +: DIV_W];
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
         if (io.clear_lost) loss_q <= '0;
`endif
         case (st)
            WAIT_LOCK: begin
               sys_rst_q <= 1'b0;
               if (lock_s) begin
                  st   <= FILTER;
                  fcnt <= '0;
               end
            end
            FILTER: begin
               if (!lock_s) begin
                  st <= WAIT_LOCK;
               end else if (fcnt == F_LAST) begin
                  st   <= HOLD;
                  hcnt <= '0;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  st <= WAIT_LOCK;
               end else if (hcnt == H_LAST) begin
                  st        <= RUN;
                  sys_rst_q <= 1'b1;
                  ce_q      <= '1;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  st        <= WAIT_LOCK;
                  sys_rst_q <= 1'b0;
                  lost_q    <= 1'b1;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
                  if (io.clear_lost)         loss_q <= 8'd1;
                  else if (loss_q != 8'hFF)  loss_q <= loss_q + 1'b1;
`endif
               end else begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (cnt[i] == '0) ce_q[i] <= 1'b1;
                     else              cnt[i]  <= cnt[i] - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign io.sys_reset_n = sys_rst_q;
   assign io.ce          = ce_q;
   assign io.lock_lost   = lost_q;
   assign io.state       = st;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
   assign io.loss_count  = loss_q;
`endif
endmodule

// File: tb/tb_clock_manager.sv
// tb/tb_clock_manager.sv - self-checking bench for clock_manager.
// Optional CLOCK_MANAGER_LOSS_COUNT_EN enables the loss_count checks.
module tb_clock_manager;
   localparam int NUM_CH = 3;
   localparam int DIV_W  = 8;
   localparam int LF     = 1024;
   localparam int RH     = 16;

   logic clock_in = 1'b0;
   logic reset_n  = 1'b0;

   clock_manager_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) io ();

   clock_manager #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LF), .RESET_HOLD(RH)
   ) dut (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .io      (io.slave)
   );

   always #5 clock_in = ~clock_in;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   always @(posedge clock_in) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: the FSM state is a pure function of how many consecutive edges
   // have seen the synchronised lock high; ce pulses are scheduled in absolute time.
   bit   m_p0 = 0, m_p1 = 0, m_ls = 0, m_was_run = 0, m_evt = 0;
   int   streak = 0, m_state = 0, m_loss = 0, tnow = 0;
   bit   m_lost = 0;
   logic [NUM_CH-1:0] m_ce = '0;
   int   next_pulse [NUM_CH];

   always @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         m_p0 = 0; m_p1 = 0; streak = 0; m_state = 0;
         m_lost = 0; m_loss = 0; m_ce = '0;
      end else begin
         m_ls = m_p1; m_p1 = m_p0; m_p0 = io.locked;
         m_was_run = (m_state == 3);
         if (m_ls) begin
            if (streak < 1000000) streak++;
         end else streak = 0;
         if (streak == 0)            m_state = 0;
         else if (streak <= LF)      m_state = 1;
         else if (streak <= LF + RH) m_state = 2;
         else                        m_state = 3;
         m_evt  = m_was_run && !m_ls;
         m_lost = m_evt || (m_lost && !io.clear_lost);
         if (m_evt)              m_loss = io.clear_lost ? 1 : (m_loss < 255 ? m_loss + 1 : 255);
         else if (io.clear_lost) m_loss = 0;
         tnow++;
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_state == 3 && (!m_was_run || tnow == next_pulse[i])) begin
               m_ce[i] = 1'b1;
               next_pulse[i] = tnow + int'(io.div_in[i*DIV_W +: DIV_W]) + 1;
            end else m_ce[i] = 1'b0;
         end
      end
   end

   always begin
      @(posedge clock_in);
      #3;
      check("state", int'(io.state), m_state);
      check("sys_reset_n", int'(io.sys_reset_n), int'(m_state == 3));
      check("ce", int'(io.ce), int'(m_ce));
      check("lock_lost", int'(io.lock_lost), int'(m_lost));
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("loss_count", int'(io.loss_count), m_loss);
`endif
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic wait_run(output int w);
      w = 0;
      do begin @(negedge clock_in); w++; end
      while (io.sys_reset_n !== 1'b1 && w < 3000);
      check("wait_run_bound", int'(w < 3000), 1);
   endtask

   task automatic wait_ce2(output int n);
      n = 0;
      do begin @(negedge clock_in); n++; end
      while (io.ce[2] !== 1'b1 && n < 50);
   endtask

   task automatic drop_relock(input string tag);
      int w;
      io.locked = 1'b0;
      tick(3);
      check({tag, "_wait"}, int'(io.state), 0);
      io.locked = 1'b1;
      wait_run(w);
      check({tag, "_relock"}, w, 1043);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, n, c0, c1, c2;
      io.locked     = 1'b0;
      io.clear_lost = 1'b0;
      io.div_in     = {8'd9, 8'd1, 8'd0};
      tick(5);
      check("rst_state", int'(io.state), 0);
      check("rst_sys_reset_n", int'(io.sys_reset_n), 0);
      check("rst_ce", int'(io.ce), 0);
      check("rst_lock_lost", int'(io.lock_lost), 0);
      reset_n = 1'b1;

      // locked sampled on cycle 10: 2 sync + 1024 filter + 16 hold -> RUN on 1052
      tick(9);
      io.locked = 1'b1;
      wait_run(w);
      check("run_latency", 9 + w, 1052);
      check("first_ce", int'(io.ce), 7);
      check("model_first_ce", int'(m_ce), 7);
      check("model_state_run", m_state, 3);

      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 0; k < 20; k++) begin
         c0 += int'(io.ce[0]); c1 += int'(io.ce[1]); c2 += int'(io.ce[2]);
         tick(1);
      end
      check("ce0_count20", c0, 20);
      check("ce1_count20", c1, 10);
      check("ce2_count20", c2, 2);

      // sitting on a ch2 pulse; retune 9 -> 3 four cycles into the period
      tick(4);
      io.div_in[23:16] = 8'd3;
      wait_ce2(n); check("div_change_gap0", n, 6);
      wait_ce2(n); check("div_change_gap1", n, 4);
      wait_ce2(n); check("div_change_gap2", n, 4);

      io.locked = 1'b0;
      tick(1); check("drop_d1_sys", int'(io.sys_reset_n), 1);
      tick(1); check("drop_d2_sys", int'(io.sys_reset_n), 1);
      tick(1); check("drop_d3_sys", int'(io.sys_reset_n), 0);
      check("drop_ce", int'(io.ce), 0);
      check("drop_lock_lost", int'(io.lock_lost), 1);

      io.locked = 1'b1;
      tick(500);
      check("glitch_in_filter", int'(io.state), 1);
      io.locked = 1'b0;
      tick(1);
      io.locked = 1'b1;
      tick(2);
      check("glitch_wait", int'(io.state), 0);
      wait_run(w);
      check("glitch_run", 2 + w, 1043);
      check("lost_sticky", int'(io.lock_lost), 1);
      io.clear_lost = 1'b1;
      tick(1);
      io.clear_lost = 1'b0;
      check("lost_cleared", int'(io.lock_lost), 0);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("loss_cleared", int'(io.loss_count), 0);
`endif

      io.div_in[15:8] = 8'd255;
      tick(300);
      drop_relock("drop1");
      drop_relock("drop2");
      drop_relock("drop3");
      check("lost_after3", int'(io.lock_lost), 1);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("loss_count3", int'(io.loss_count), 3);
`endif

      io.locked = 1'b0;
      tick(2);
      io.clear_lost = 1'b1;
      tick(1);
      io.clear_lost = 1'b0;
      check("coinc_state", int'(io.state), 0);
      check("coinc_lock_lost", int'(io.lock_lost), 1);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("coinc_loss_count", int'(io.loss_count), 1);
`endif

      io.locked = 1'b1;
      wait_run(w);
      tick(5);
      reset_n = 1'b0;
      #1;
      check("midrst_state", int'(io.state), 0);
      check("midrst_sys", int'(io.sys_reset_n), 0);
      check("midrst_ce", int'(io.ce), 0);
      check("midrst_lost", int'(io.lock_lost), 0);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("midrst_loss", int'(io.loss_count), 0);
`endif
      tick(2);
      reset_n = 1'b1;
      wait_run(w);
      check("post_reset_run", w, 1043);
      tick(3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/clock_manager.md
Name: clock_manager

Overview:
- Clock-domain housekeeping block; runs on the PLL output clock and sits directly after the PLL wrapper in the top level.
- Filters the asynchronous PLL lock indication and sequences a clean synchronous system reset.
- Generates NUM_CH independently programmable clock-enable strobes for slower subsystems (CPU, UART, video).
- Re-enters reset on any loss of lock.

Parameters:
- NUM_CH, 3, number of clock-enable channels (1..8)
- DIV_W, 8, width of each channel divisor
- LOCK_FILTER, 1024, consecutive synchronised-locked cycles required before leaving FILTER (>=1)
- RESET_HOLD, 16, cycles sys_reset_n is held low in HOLD after the filter passes (>=1)

Ports:
- clock_in  input  1  PLL output clock; only clock of the block
- reset_n  input  1  asynchronous active-low reset
- locked  input  1  PLL lock, asynchronous to clock_in
- div_in  input  NUM_CH*DIV_W  packed divisors; channel i at [i*DIV_W +: DIV_W]
- clear_lost  input  1  synchronous clear of lock_lost
- sys_reset_n  output  1  synchronous active-low system reset
- ce  output  NUM_CH  one-cycle clock-enable pulses, one bit per channel
- lock_lost  output  1  sticky: lock dropped while in RUN
- state  output  2  FSM state: 0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RUN

Behaviour:
- Reset values (reset_n low, asynchronous): sys_reset_n=0, ce=0, lock_lost=0, state=WAIT_LOCK. Synchroniser flops, counters and shadow divisors are all 0.
- Lock synchroniser: locked passes through 2 flops to give lock_s. Latency is 2 cycles.
- WAIT_LOCK: sys_reset_n=0. When lock_s=1, go to FILTER and clear the filter counter.
- FILTER: counter increments while lock_s=1. When lock_s=0, return to WAIT_LOCK. After LOCK_FILTER consecutive cycles at 1, go to HOLD.
- HOLD: sys_reset_n stays 0 for RESET_HOLD cycles, then go to RUN. If lock_s=0 during HOLD, return to WAIT_LOCK.
- RUN: sys_reset_n=1, registered, asserted on the first RUN cycle. When lock_s=0, go to WAIT_LOCK; sys_reset_n=0 on the following cycle and lock_lost is set.
- Lock-loss timing: total delay from the locked pin falling to sys_reset_n low is 3 cycles.
- lock_lost: sticky. Cleared by clear_lost=1. If a set and a clear happen in the same cycle, set wins.
- Clock-enable channels:
  - Each channel has a DIV_W-bit down-counter and a shadow divisor, both active only in RUN.
  - Outside RUN, counters and shadows load from div_in and ce=0.
  - In RUN, ce[i]=1 for the single cycle in which the counter is 0. On that cycle the counter reloads from div_in[i]; the shadow captures it. Otherwise the counter decrements.
  - Period is div+1 cycles.
  - The first ce pulse of each channel occurs on the first RUN cycle.
  - Divisor 0 gives ce[i] held at 1 every RUN cycle.
  - A divisor change applies only at the next reload. There is no mid-period glitch.
  - Maximum divisor is 2^DIV_W-1, with no wrap beyond it.
- Counter widths: filter and hold counters are sized with clog2 of their parameter plus 1. They saturate at terminal count and never wrap.
- reset_n asserted mid-operation: everything returns to reset values immediately. After release, the FSM restarts in WAIT_LOCK.

Optional Feature:
- Macro: CLOCK_MANAGER_LOSS_COUNT_EN.
- When defined:
  - Adds output loss_count, 8 bits.
  - Increments on each RUN->WAIT_LOCK transition and saturates at 255.
  - Cleared by clear_lost together with lock_lost; on the same cycle, the increment wins, so the count becomes 1.
  - Reset value is 0.
- When undefined: the port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then lock: reset_n low 5 cycles, locked=1 from cycle 10, LOCK_FILTER=1024, RESET_HOLD=16 -> state reaches RUN and sys_reset_n rises on cycle 10+2+1024+16 (±1 for state-entry cycles, documented in the bench), not before.
- Glitchy lock: locked pulses low 1 cycle at FILTER count 500 -> state returns to WAIT_LOCK, filter restarts, RUN delayed by a full 1024+16 cycles.
- Divisors 0/1/9 on channels 0/1/2 in RUN -> ce[0] high every cycle; ce[1] every 2nd cycle; ce[2] every 10th cycle; all three pulse on the first RUN cycle.
- Change div channel 2 from 9 to 3 mid-period -> the current 10-cycle period completes, then 4-cycle periods follow; no short pulse.
- Lock drops in RUN -> sys_reset_n low 3 cycles after the locked edge; ce all 0; lock_lost=1 and stays 1 through relock; clear_lost pulse -> 0.
- With CLOCK_MANAGER_LOSS_COUNT_EN: 3 lock drops -> loss_count=3; clear_lost coincident with a 4th drop -> loss_count=1, lock_lost=1.
